// File: rtl/tthbif_regif_pkg.sv
// Shared definitions for the tthbif UART register interface:
// FSM states, register map, reset values, response codes, command fields.
package tthbif_regif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_RESP      = 2'd2
    } state_e;

    // Register addresses
    localparam logic [3:0] ADDR_RX_TAP = 4'd0;
    localparam logic [3:0] ADDR_TX_TAP = 4'd1;
    localparam logic [3:0] ADDR_CTRL   = 4'd2;
    localparam logic [3:0] ADDR_ID     = 4'd3;

    // Register reset values
    localparam logic [7:0] RST_RX_TAP = 8'h0F;
    localparam logic [7:0] RST_TX_TAP = 8'h0F;
    localparam logic [7:0] RST_CTRL   = 8'h01;

    // Response codes
    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_NAK = 8'h15;

    // Command byte fields
    localparam int CMD_WR_BIT  = 7;
    localparam int CMD_RSV_HI  = 6;
    localparam int CMD_RSV_LO  = 4;
    localparam int CMD_ADDR_HI = 3;
    localparam int CMD_ADDR_LO = 0;

    // True when the reserved command bits are all zero
    function automatic logic cmd_rsv_clear(input logic [7:0] cmd);
        return cmd[CMD_RSV_HI:CMD_RSV_LO] == 3'b000;
    endfunction

    function automatic logic [3:0] cmd_addr(input logic [7:0] cmd);
        return cmd[CMD_ADDR_HI:CMD_ADDR_LO];
    endfunction

endpackage

// File: rtl/tthbif_uart_regif.sv
// UART command responder: decodes host read/write commands into a
// 4-entry byte register file driving tthbif tap selects and enable,
// and returns exactly one response byte per completed command.
module tthbif_uart_regif
    import tthbif_regif_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1048576,
    parameter logic [7:0] ID_VALUE       = 8'h48
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_data_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       tx_data_ready_i,
    output logic       tx_data_valid_o,
    output logic [7:0] tx_data_o,
    output logic       en_o,
    output logic [1:0] rx_flop_tap_sel_o,
    output logic [1:0] rx_comb_tap_sel_o,
    output logic [1:0] tx_flop_tap_sel_o,
    output logic [1:0] tx_comb_tap_sel_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state;
    logic [7:0]       reg0;
    logic [7:0]       reg1;
    logic [7:0]       reg2;
    logic [CNT_W-1:0] to_cnt;
    logic [3:0]       wr_addr_q;
    logic             wr_ok_q;
    logic [7:0]       rd_data;
    logic             rd_ok;

    // Read mux on the incoming command byte; data is sampled at decode
    always_comb begin
        rd_data = 8'h00;
        rd_ok   = cmd_rsv_clear(rx_data_i) && (cmd_addr(rx_data_i) <= ADDR_ID);
        case (cmd_addr(rx_data_i))
            ADDR_RX_TAP: rd_data = reg0;
            ADDR_TX_TAP: rd_data = reg1;
            ADDR_CTRL:   rd_data = reg2;
            ADDR_ID:     rd_data = ID_VALUE;
            default:     rd_data = 8'h00;
        endcase
    end

    // Command FSM, timeout counter and register file
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            tx_data_valid_o <= 1'b0;
            tx_data_o       <= 8'h00;
            reg0            <= RST_RX_TAP;
            reg1            <= RST_TX_TAP;
            reg2            <= RST_CTRL;
            to_cnt          <= '0;
            wr_addr_q       <= 4'd0;
            wr_ok_q         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_data_valid_i) begin
                        if (rx_data_i[CMD_WR_BIT]) begin
                            // Validity is resolved now so the data phase only needs two bits
                            wr_addr_q <= cmd_addr(rx_data_i);
                            wr_ok_q   <= cmd_rsv_clear(rx_data_i) &&
                                         (cmd_addr(rx_data_i) <= ADDR_CTRL);
                            to_cnt    <= '0;
                            state     <= ST_WAIT_DATA;
                        end else begin
                            tx_data_o       <= rd_ok ? rd_data : RESP_NAK;
                            tx_data_valid_o <= 1'b1;
                            state           <= ST_RESP;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    // A byte on the last counted cycle still wins over the abort
                    if (rx_data_valid_i) begin
                        if (wr_ok_q) begin
                            case (wr_addr_q)
                                ADDR_RX_TAP: reg0 <= rx_data_i;
                                ADDR_TX_TAP: reg1 <= rx_data_i;
                                default: begin
                                    reg2[6:0] <= rx_data_i[6:0];
                                    if (rx_data_i[7])
                                        reg2[7] <= 1'b0;
                                end
                            endcase
                            tx_data_o <= RESP_ACK;
                        end else begin
                            tx_data_o <= RESP_NAK;
                        end
                        tx_data_valid_o <= 1'b1;
                        state           <= ST_RESP;
                    end else if (to_cnt == TO_LAST) begin
                        state <= ST_IDLE;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (tx_data_ready_i) begin
                        tx_data_valid_o <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                default: begin
                    tx_data_valid_o <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
            // Overrun: placed last so a set beats any clear in the same cycle
            if (state == ST_RESP && rx_data_valid_i)
                reg2[7] <= 1'b1;
        end
    end

    assign en_o              = reg2[0];
    assign rx_flop_tap_sel_o = reg0[1:0];
    assign rx_comb_tap_sel_o = reg0[3:2];
    assign tx_flop_tap_sel_o = reg1[1:0];
    assign tx_comb_tap_sel_o = reg1[3:2];

endmodule

// File: tb/tb_tthbif_uart_regif.sv
// Directed bench for tthbif_uart_regif with an expected-response queue.
module tb_tthbif_uart_regif;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       rx_data_valid_i;
    logic [7:0] rx_data_i;
    logic       tx_data_ready_i;
    logic       tx_data_valid_o;
    logic [7:0] tx_data_o;
    logic       en_o;
    logic [1:0] rx_flop_tap_sel_o, rx_comb_tap_sel_o;
    logic [1:0] tx_flop_tap_sel_o, tx_comb_tap_sel_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    tthbif_uart_regif #(.TIMEOUT_CYCLES(TO), .ID_VALUE(8'h48)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .rx_data_valid_i(rx_data_valid_i), .rx_data_i(rx_data_i),
        .tx_data_ready_i(tx_data_ready_i),
        .tx_data_valid_o(tx_data_valid_o), .tx_data_o(tx_data_o),
        .en_o(en_o),
        .rx_flop_tap_sel_o(rx_flop_tap_sel_o), .rx_comb_tap_sel_o(rx_comb_tap_sel_o),
        .tx_flop_tap_sel_o(tx_flop_tap_sel_o), .tx_comb_tap_sel_o(tx_comb_tap_sel_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte is presented for one cycle and captured on the posedge in between
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data_valid_i = 1'b1;
        rx_data_i       = b;
        @(negedge clk);
        rx_data_valid_i = 1'b0;
    endtask

    // Waits (bounded) for a response, compares against the queue head, completes the handshake
    task automatic get_resp(input string tag);
        int n = 0;
        logic [7:0] exp;
        while (!tx_data_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(tx_data_valid_o), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, 32'(tx_data_o), 32'(exp));
        end
        tx_data_ready_i = 1'b1;
        @(negedge clk);
        chk({tag, "_drop"}, 32'(tx_data_valid_o), 32'd0);
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx_data_valid_o) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [7:0] held;
        logic       stable;
        rst_i = 1'b1;
        rx_data_valid_i = 1'b0;
        rx_data_i = 8'h00;
        tx_data_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(tx_data_valid_o), 32'd0);
        chk("rst_data", 32'(tx_data_o), 32'h00);
        chk("rst_en", 32'(en_o), 32'd1);
        chk("rst_sel", {24'd0, rx_flop_tap_sel_o, rx_comb_tap_sel_o,
                        tx_flop_tap_sel_o, tx_comb_tap_sel_o}, 32'hFF);
        rst_i = 1'b0;

        // Reads of all four registers
        exp_q.push_back(8'h0F); send(8'h00); get_resp("rd0");
        exp_q.push_back(8'h0F); send(8'h01); get_resp("rd1");
        exp_q.push_back(8'h01); send(8'h02); get_resp("rd2");
        exp_q.push_back(8'h48); send(8'h03); get_resp("rd3");

        // Write reg0 = 0x06; outputs visible right after the data edge
        send(8'h80);
        exp_q.push_back(8'h06); send(8'h06);
        chk("wr0_flop", 32'(rx_flop_tap_sel_o), 32'd2);
        chk("wr0_comb", 32'(rx_comb_tap_sel_o), 32'd1);
        get_resp("wr0_ack");
        exp_q.push_back(8'h06); send(8'h00); get_resp("rd0_after_wr");

        // Illegal writes / reads
        send(8'h83); exp_q.push_back(8'h15); send(8'hFF); get_resp("wr3_nak");
        send(8'h85); exp_q.push_back(8'h15); send(8'h00); get_resp("wr5_nak");
        exp_q.push_back(8'h15); send(8'h45); get_resp("rd_rsv_nak");
        exp_q.push_back(8'h06); send(8'h00); get_resp("rd0_unchanged");
        exp_q.push_back(8'h0F); send(8'h01); get_resp("rd1_unchanged");
        exp_q.push_back(8'h01); send(8'h02); get_resp("rd2_unchanged");

        // Back-pressure with an overrun byte injected mid-stall
        tx_data_ready_i = 1'b0;
        exp_q.push_back(8'h06); send(8'h00);
        held = tx_data_o;
        stable = tx_data_valid_o;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                rx_data_valid_i = 1'b1; rx_data_i = 8'h02;
            end else begin
                rx_data_valid_i = 1'b0;
            end
            @(negedge clk);
            if (!tx_data_valid_o || tx_data_o !== held) stable = 1'b0;
        end
        rx_data_valid_i = 1'b0;
        chk("stall_stable", 32'(stable), 32'd1);
        get_resp("stall_resp");
        expect_silence("overrun_dropped", 5);
        exp_q.push_back(8'h81); send(8'h02); get_resp("rd2_overrun");
        send(8'h82); exp_q.push_back(8'h06); send(8'h81); get_resp("w1c_ack");
        chk("w1c_en", 32'(en_o), 32'd1);
        exp_q.push_back(8'h01); send(8'h02); get_resp("rd2_cleared");

        // Timeout: write command with no data byte
        send(8'h81);
        expect_silence("timeout_silent", TO + 4);
        exp_q.push_back(8'h0F); send(8'h01); get_resp("rd1_after_to");

        // Data byte on the very last cycle before abort is still accepted
        send(8'h81);
        repeat (TO - 2) @(negedge clk);
        exp_q.push_back(8'h06); send(8'h0A);
        chk("late_flop", 32'(tx_flop_tap_sel_o), 32'd2);
        chk("late_comb", 32'(tx_comb_tap_sel_o), 32'd2);
        get_resp("late_ack");

        // Reset during a pending write
        send(8'h82); exp_q.push_back(8'h06); send(8'h00);
        chk("en_cleared", 32'(en_o), 32'd0);
        get_resp("ctrl0_ack");
        send(8'h82);
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        chk("rst_mid_en", 32'(en_o), 32'd1);
        expect_silence("rst_mid_silent", 5);
        exp_q.push_back(8'h01); send(8'h02); get_resp("rd2_post_rst");
        exp_q.push_back(8'h0F); send(8'h01); get_resp("rd1_post_rst");

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
